// File: rtl/led_pkg.sv
// Shared types and default sizing for the LED fade/PWM stage.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    HOLD = 2'd2,
    FALL = 2'd3
  } state_t;

  localparam int DEF_PWM_BITS = 8;
  localparam int DEF_STEP_DIV = 4;
  localparam int DEF_DUTY_MAX = 255;

  // Counter width that stays at least one bit when the modulus is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_fade_pwm_if.sv
// Blink input / LED drive bundle between the blinker and the fade stage.
interface led_fade_pwm_if #(
  parameter int PWM_BITS = led_pkg::DEF_PWM_BITS
);
  logic                blink_in;
  logic                enable;
  logic                led_out;
  logic [PWM_BITS-1:0] duty;
  logic                fading;

  modport master (output blink_in, enable, input led_out, duty, fading);
  modport slave  (input blink_in, enable, output led_out, duty, fading);
endinterface

// File: rtl/led_fade_pwm_pwm_gen.sv
// Free-running PWM counter with a registered duty compare.
module pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_in,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] duty,
  output logic                period_end,
  output logic                led_out
);
  logic [PWM_BITS-1:0] pwm_cnt;

  assign period_end = (pwm_cnt == '1);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
      led_out <= 1'b0;
    end else if (!enable) begin
      pwm_cnt <= '0;
      led_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      led_out <= (pwm_cnt < duty);
    end
  end
endmodule

// File: rtl/led_fade_pwm.sv
// Breathing LED: ramps PWM duty up while blink is high, down while low.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int STEP_DIV = DEF_STEP_DIV,
  parameter int DUTY_MAX = DEF_DUTY_MAX
) (
  input  logic          clk_in,
  input  logic          reset_n,
  led_fade_pwm_if.slave bus
);
  localparam int                  STEP_W = cnt_w(STEP_DIV);
  localparam logic [PWM_BITS-1:0] DMAX   = PWM_BITS'(DUTY_MAX);
  localparam logic [STEP_W-1:0]   SLAST  = STEP_W'(STEP_DIV - 1);

  state_t              state_q, state_n;
  logic [PWM_BITS-1:0] duty_q, duty_n;
  logic [STEP_W-1:0]   step_cnt;
  logic                blink_q, fading_q;
  logic                period_end, step_strobe, led;

  assign step_strobe = period_end && (step_cnt == SLAST);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      blink_q  <= 1'b0;
      state_q  <= IDLE;
      duty_q   <= '0;
      step_cnt <= '0;
      fading_q <= 1'b0;
    end else begin
      blink_q  <= bus.blink_in;
      state_q  <= state_n;
      duty_q   <= duty_n;
      fading_q <= (state_n == RISE) || (state_n == FALL);
      if (!bus.enable)     step_cnt <= '0;
      else if (period_end) step_cnt <= step_strobe ? '0 : step_cnt + STEP_W'(1);
    end
  end

  // The step uses the current direction; a blink reversal only retargets
  // the state, so duty never jumps when the input flips mid-ramp.
  always_comb begin
    state_n = state_q;
    duty_n  = duty_q;
    if (!bus.enable) begin
      state_n = IDLE;
      duty_n  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          duty_n = '0;
          if (blink_q) state_n = RISE;
        end
        RISE: begin
          if (step_strobe && duty_q < DMAX) duty_n = duty_q + PWM_BITS'(1);
          if (!blink_q)            state_n = FALL;
          else if (duty_n == DMAX) state_n = HOLD;
        end
        HOLD: begin
          if (!blink_q) state_n = FALL;
        end
        FALL: begin
          if (step_strobe && duty_q != '0) duty_n = duty_q - PWM_BITS'(1);
          if (blink_q)           state_n = RISE;
          else if (duty_n == '0) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .enable     (bus.enable),
    .duty       (duty_q),
    .period_end (period_end),
    .led_out    (led)
  );

  assign bus.led_out = led;
  assign bus.duty    = duty_q;
  assign bus.fading  = fading_q;
endmodule
